osd_ctrl: RTL and testbench
===========================

OSD_CTRL -- requirements
Module: osd_ctrl

Interface
REQ-001 Parameter HIDE_TICKS, default 24'd16000000, auto-hide timeout in clk_sys cycles (used only with OSD_AUTOHIDE_EN).
REQ-002 clk_sys  in  1  single system clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 spi_cmd_stb  in  1  one-cycle strobe: first byte of an SPI transaction is valid on spi_cmd.
REQ-005 spi_cmd  in  8  command byte.
REQ-006 spi_dat_stb  in  1  one-cycle strobe: payload byte is valid on spi_dat.
REQ-007 spi_dat  in  8  payload byte.
REQ-008 spi_end  in  1  one-cycle strobe: SPI select deasserted, transaction over.
REQ-009 core_req  in  1  core-side write request; held with core_addr/core_data stable until core_ack.
REQ-010 core_addr  in  11  core write address into the 2048-byte OSD buffer.
REQ-011 core_data  in  8  core write data.
REQ-012 core_ack  out  1  one-cycle pulse: core write issued.
REQ-013 buf_we  out  1  OSD buffer write enable, registered.
REQ-014 buf_addr  out  11  OSD buffer write address, registered.
REQ-015 buf_wdata  out  8  OSD buffer write data, registered.
REQ-016 osd_enable  out  1  OSD visible.
REQ-017 spi_busy  out  1  high while FSM is not IDLE.

Function
REQ-018 FSM states: IDLE, WRITE (payload goes to buffer), OTHER (payload discarded).
REQ-019 Command decode is applied on spi_cmd_stb in any state:
- spi_cmd[7:3]=5'b00100 -> WRITE, address counter loaded with {spi_cmd[2:0],8'h00};
- spi_cmd[7:4]=4'h4 -> OTHER, osd_enable <= spi_cmd[0];
- any other command -> OTHER.
REQ-020 spi_end in any state -> IDLE; spi_end has priority over spi_cmd_stb and spi_dat_stb in the same cycle, and those strobes are ignored.
REQ-021 In WRITE, spi_dat_stb in cycle N -> buf_we=1, buf_addr=counter, buf_wdata=spi_dat in cycle N+1; counter increments by 1 and wraps 2047->0.
REQ-022 spi_dat_stb in IDLE or OTHER produces no write.
REQ-023 Arbitration is fixed priority, SPI first. In cycle N, if a WRITE-state spi_dat_stb is present, core_req is not served. Otherwise, if core_req=1 and core_ack=0, then in cycle N+1: buf_we=1, buf_addr=core_addr, buf_wdata=core_data, core_ack=1.
REQ-024 core_ack is never high on two consecutive cycles; a core_req still high after core_ack is a new request.
REQ-025 With no accepted source in cycle N, buf_we=0 in cycle N+1; buf_addr and buf_wdata hold their values.
REQ-026 Core writes are permitted in any FSM state, including during an SPI transaction, subject only to REQ-023.
REQ-027 spi_busy is combinational from the state register (state != IDLE).

Reset
REQ-028 On reset: state IDLE; address counter 0; buf_we, buf_addr, buf_wdata, core_ack, osd_enable all 0; auto-hide counter 0.
REQ-029 Reset asserted mid-transaction aborts it. No write is issued in the cycle after reset. Strobes arriving while reset is high are ignored.

Configuration
REQ-030 Macro OSD_AUTOHIDE_EN defined: a 24-bit down-counter reloads to HIDE_TICKS on any spi_cmd_stb, spi_dat_stb, or spi_end, and decrements while osd_enable=1 and the counter is nonzero. When it reaches 1 -> 0, osd_enable is cleared in the same cycle. An enable command in the same cycle as expiry wins, and the counter reloads.
REQ-031 Macro OSD_AUTOHIDE_EN undefined: no counter is instantiated, and osd_enable changes only via REQ-019 and reset.

Verification
REQ-032 cmd 0x22, then payload bytes 0xAA and 0x55 -> writes (0x200, 0xAA) then (0x201, 0x55), each one cycle after its strobe; spi_busy=1 until spi_end.
REQ-033 cmd 0x27, then 257 payload bytes -> the 256th byte is written to 0x7FF and the 257th to 0x000 (wrap).
REQ-034 cmd 0x41 -> osd_enable=1 one cycle later; cmd 0x40 -> osd_enable=0; a following payload byte produces no buf_we.
REQ-035 core_req with addr 0x123 and data 0x5A, asserted in the same cycle as a WRITE-state spi_dat_stb -> SPI write first, core write and core_ack in the following cycle, with exactly one ack.
REQ-036 spi_end and spi_dat_stb in the same cycle in WRITE -> no write, state IDLE. Reset asserted between two payload bytes -> all outputs 0, and a later payload without a new command produces no write.
REQ-037 With OSD_AUTOHIDE_EN and HIDE_TICKS=10: cmd 0x41 followed by no SPI activity -> osd_enable drops exactly 10 cycles after the spi_end that closes the transaction.

Source files
------------

// File: rtl/osd_ctrl.sv
// OSD controller: decodes SPI OSD commands, streams SPI payload into the 2 KiB OSD
// buffer, and merges core-side writes behind SPI. Optional auto-hide: OSD_AUTOHIDE_EN.
module osd_ctrl #(
    parameter logic [23:0] HIDE_TICKS = 24'd16000000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        spi_cmd_stb,
    input  logic [7:0]  spi_cmd,
    input  logic        spi_dat_stb,
    input  logic [7:0]  spi_dat,
    input  logic        spi_end,
    input  logic        core_req,
    input  logic [10:0] core_addr,
    input  logic [7:0]  core_data,
    output logic        core_ack,
    output logic        buf_we,
    output logic [10:0] buf_addr,
    output logic [7:0]  buf_wdata,
    output logic        osd_enable,
    output logic        spi_busy
);

    typedef enum logic [1:0] {IDLE, WRITE, OTHER} state_t;

    state_t      state, state_nx;
    logic [10:0] wr_ptr;
    logic        cmd_vld, cmd_is_wr, cmd_is_osd;
    logic        spi_wr, core_wr;

    // spi_end masks any strobe arriving with it
    assign cmd_vld    = spi_cmd_stb & ~spi_end;
    assign cmd_is_wr  = (spi_cmd[7:3] == 5'b00100);
    assign cmd_is_osd = (spi_cmd[7:4] == 4'h4);
    assign spi_wr     = (state == WRITE) & spi_dat_stb & ~spi_end;
    assign core_wr    = core_req & ~core_ack & ~spi_wr;
    assign spi_busy   = (state != IDLE);

    always_comb begin
        state_nx = state;
        if (spi_end)
            state_nx = IDLE;
        else if (spi_cmd_stb)
            state_nx = cmd_is_wr ? WRITE : OTHER;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state  <= IDLE;
            wr_ptr <= '0;
        end else begin
            state <= state_nx;
            if (cmd_vld && cmd_is_wr)
                wr_ptr <= {spi_cmd[2:0], 8'h00};
            else if (spi_wr)
                wr_ptr <= wr_ptr + 11'd1;
        end
    end

    // Buffer write port: SPI payload wins, core is served on any other cycle
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            buf_we    <= 1'b0;
            buf_addr  <= '0;
            buf_wdata <= '0;
            core_ack  <= 1'b0;
        end else begin
            buf_we   <= spi_wr | core_wr;
            core_ack <= core_wr;
            if (spi_wr) begin
                buf_addr  <= wr_ptr;
                buf_wdata <= spi_dat;
            end else if (core_wr) begin
                buf_addr  <= core_addr;
                buf_wdata <= core_data;
            end
        end
    end

`ifdef OSD_AUTOHIDE_EN
    logic [23:0] hide_cnt;
    logic        spi_act;

    assign spi_act = spi_cmd_stb | spi_dat_stb | spi_end;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hide_cnt   <= '0;
            osd_enable <= 1'b0;
        end else begin
            if (spi_act)
                hide_cnt <= HIDE_TICKS;
            else if (osd_enable && hide_cnt != 24'd0)
                hide_cnt <= hide_cnt - 24'd1;
            // an enable command on the expiry cycle keeps the OSD up
            if (cmd_vld && cmd_is_osd)
                osd_enable <= spi_cmd[0];
            else if (!spi_act && osd_enable && hide_cnt == 24'd1)
                osd_enable <= 1'b0;
        end
    end
`else
    logic unused_hide;
    assign unused_hide = ^HIDE_TICKS;

    always_ff @(posedge clk_sys) begin
        if (reset)
            osd_enable <= 1'b0;
        else if (cmd_vld && cmd_is_osd)
            osd_enable <= spi_cmd[0];
    end
`endif

endmodule

// File: tb/tb_osd_ctrl.sv
// Random + directed bench for osd_ctrl against a transaction-level reference model.
module tb_osd_ctrl;

    localparam logic [23:0] HT = 24'd10;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        spi_cmd_stb = 1'b0, spi_dat_stb = 1'b0, spi_end = 1'b0;
    logic [7:0]  spi_cmd = '0, spi_dat = '0;
    logic        core_req = 1'b0;
    logic [10:0] core_addr = '0;
    logic [7:0]  core_data = '0;
    logic        core_ack, buf_we, osd_enable, spi_busy;
    logic [10:0] buf_addr;
    logic [7:0]  buf_wdata;

    osd_ctrl #(.HIDE_TICKS(HT)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .spi_cmd_stb(spi_cmd_stb), .spi_cmd(spi_cmd),
        .spi_dat_stb(spi_dat_stb), .spi_dat(spi_dat), .spi_end(spi_end),
        .core_req(core_req), .core_addr(core_addr), .core_data(core_data),
        .core_ack(core_ack), .buf_we(buf_we), .buf_addr(buf_addr),
        .buf_wdata(buf_wdata), .osd_enable(osd_enable), .spi_busy(spi_busy)
    );

    always #5 clk_sys = ~clk_sys;

    int total = 0, bad = 0, acks = 0;

    // reference model: mode 0=idle 1=write 2=other
    int m_mode = 0, m_ptr = 0, m_addr = 0, m_dat = 0, m_hide = 0;
    bit m_we = 0, m_ack = 0, m_en = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        bit sw, cw;
        if (reset) begin
            m_mode = 0; m_ptr = 0; m_we = 0; m_addr = 0; m_dat = 0;
            m_ack = 0; m_en = 0; m_hide = 0;
        end else begin
            sw = (m_mode == 1) && spi_dat_stb && !spi_end;
            cw = core_req && !m_ack && !sw;
            m_we = sw || cw;
            if (sw) begin
                m_addr = m_ptr; m_dat = spi_dat; m_ptr = (m_ptr + 1) % 2048;
            end else if (cw) begin
                m_addr = core_addr; m_dat = core_data;
            end
            m_ack = cw;
`ifdef OSD_AUTOHIDE_EN
            if (spi_cmd_stb || spi_dat_stb || spi_end) m_hide = HT;
            else if (m_en && m_hide > 0) begin
                m_hide--;
                if (m_hide == 0) m_en = 0;
            end
`endif
            if (spi_end) m_mode = 0;
            else if (spi_cmd_stb) begin
                if (spi_cmd >= 8'h20 && spi_cmd <= 8'h27) begin
                    m_mode = 1; m_ptr = (spi_cmd - 8'h20) * 256;
                end else m_mode = 2;
                if (spi_cmd >= 8'h40 && spi_cmd <= 8'h4F) m_en = spi_cmd[0];
            end
        end
        @(posedge clk_sys); #1;
        chk("busy", spi_busy, m_mode != 0);
        chk("we", buf_we, m_we);
        chk("addr", buf_addr, m_addr);
        chk("wdata", buf_wdata, m_dat);
        chk("ack", core_ack, m_ack);
        chk("en", osd_enable, m_en);
        acks += core_ack;
    endtask

    task automatic spi(input bit cs, input logic [7:0] c, input bit ds,
                       input logic [7:0] d, input bit e);
        spi_cmd_stb = cs; spi_cmd = c; spi_dat_stb = ds; spi_dat = d; spi_end = e;
        cyc();
        spi_cmd_stb = 0; spi_dat_stb = 0; spi_end = 0;
    endtask

    initial begin
        cyc(); cyc();
        reset = 0;
        cyc();
        chk("rst_we", buf_we, 0);
        chk("rst_busy", spi_busy, 0);

        // basic write stream
        spi(1, 8'h22, 0, 0, 0);
        chk("busy_w", spi_busy, 1);
        spi(0, 0, 1, 8'hAA, 0);
        chk("w0_addr", buf_addr, 11'h200); chk("w0_dat", buf_wdata, 8'hAA);
        spi(0, 0, 1, 8'h55, 0);
        chk("w1_addr", buf_addr, 11'h201); chk("w1_dat", buf_wdata, 8'h55);
        cyc();
        chk("busy_hold", spi_busy, 1);
        spi(0, 0, 0, 0, 1);
        chk("busy_end", spi_busy, 0);

        // wrap at top of buffer
        spi(1, 8'h27, 0, 0, 0);
        for (int i = 1; i <= 257; i++) begin
            spi(0, 0, 1, 8'(i), 0);
            if (i == 256) chk("wrap_hi", buf_addr, 11'h7FF);
            if (i == 257) chk("wrap_lo", buf_addr, 11'h000);
        end
        spi(0, 0, 0, 0, 1);

        // osd enable/disable, payload discarded
        spi(1, 8'h41, 0, 0, 0);
        chk("en_on", osd_enable, 1);
        spi(1, 8'h40, 0, 0, 0);
        chk("en_off", osd_enable, 0);
        spi(0, 0, 1, 8'h77, 0);
        chk("oth_we", buf_we, 0);
        spi(0, 0, 0, 0, 1);

        // SPI beats core in the same cycle; exactly one ack
        spi(1, 8'h20, 0, 0, 0);
        acks = 0;
        core_req = 1; core_addr = 11'h123; core_data = 8'h5A;
        spi(0, 0, 1, 8'hC3, 0);
        chk("arb_spi", buf_addr, 11'h000);
        chk("arb_noack", core_ack, 0);
        cyc();
        chk("arb_core", buf_addr, 11'h123);
        chk("arb_cdat", buf_wdata, 8'h5A);
        core_req = 0;
        cyc();
        chk("arb_acks", acks, 1);

        // end beats data; reset aborts a transaction
        spi(0, 0, 1, 8'h11, 1);
        chk("end_we", buf_we, 0);
        chk("end_busy", spi_busy, 0);
        spi(1, 8'h23, 0, 0, 0);
        spi(0, 0, 1, 8'h01, 0);
        reset = 1;
        spi(0, 0, 1, 8'h02, 0);
        reset = 0;
        chk("rst_addr", buf_addr, 0);
        spi(0, 0, 1, 8'h03, 0);
        chk("rst_nowr", buf_we, 0);

`ifdef OSD_AUTOHIDE_EN
        spi(1, 8'h41, 0, 0, 0);
        spi(0, 0, 0, 0, 1);
        for (int i = 1; i <= 10; i++) begin
            cyc();
            chk("hide", osd_enable, i < 10);
        end
`endif

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            int r;
            r = $urandom_range(0, 99);
            spi_cmd_stb = (r < 6);
            r = $urandom_range(0, 3);
            spi_cmd = (r == 0) ? 8'($urandom_range(8'h20, 8'h27)) :
                      (r == 1) ? 8'($urandom_range(8'h40, 8'h41)) : 8'($urandom);
            spi_dat_stb = ($urandom_range(0, 1) == 1);
            spi_dat = 8'($urandom);
            spi_end = ($urandom_range(0, 39) == 0);
            reset = ($urandom_range(0, 599) == 0);
            if (!core_req || m_ack) begin
                core_req = ($urandom_range(0, 2) == 0);
                core_addr = 11'($urandom);
                core_data = 8'($urandom);
            end
            cyc();
        end
        reset = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
